// File: rtl/fp32_result_pack.sv
// fp32_result_pack: classify and pack adder results into IEEE-754 words through a 2-entry FIFO
module fp32_result_pack (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        sign_in,
   input  logic [9:0]  exp_in,
   input  logic [22:0] sig_in,
   input  logic        zero_in,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic [2:0]  out_flags,
   output logic [15:0] result_cnt,
   output logic [7:0]  ovf_cnt
);
   logic signed [9:0] exp_s;
   logic              is_ovf, is_unf, push, pop;
   logic [31:0]       pk_data;
   logic [2:0]        pk_flags;
   logic [34:0]       mem_q [2];
   logic              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [1:0]        cnt_q, cnt_d;
   logic [15:0]       result_cnt_q, result_cnt_d;
   logic [7:0]        ovf_cnt_q, ovf_cnt_d;

   assign exp_s      = exp_in;
   assign in_ready   = cnt_q < 2'd2;
   assign out_valid  = cnt_q != 2'd0;
   assign push       = in_valid && in_ready;
   assign pop        = out_valid && out_ready;
   assign out_data   = mem_q[rd_ptr_q][31:0];
   assign out_flags  = mem_q[rd_ptr_q][34:32];
   assign result_cnt = result_cnt_q;
   assign ovf_cnt    = ovf_cnt_q;

   // classify the incoming word: zero beats overflow beats underflow beats normal
   always_comb begin
      is_ovf   = exp_s >= 10'sd255;
      is_unf   = exp_s <= 10'sd0;
      pk_data  = zero_in ? 32'h0 : is_ovf ? {sign_in, 8'hFF, 23'h0} : is_unf ? {sign_in, 31'h0} : {sign_in, exp_in[7:0], sig_in};
      pk_flags = zero_in ? 3'b001 : is_ovf ? 3'b100 : is_unf ? 3'b010 : 3'b000;
   end

   // pointer, occupancy and delivery-counter next state; ovf counter saturates
   always_comb begin
      wr_ptr_d     = wr_ptr_q ^ push;
      rd_ptr_d     = rd_ptr_q ^ pop;
      cnt_d        = cnt_q + 2'(push) - 2'(pop);
      result_cnt_d = result_cnt_q + 16'(pop);
      ovf_cnt_d    = ovf_cnt_q + 8'(pop && out_flags[2] && ovf_cnt_q != 8'hFF);
   end

   // storage carries no reset: occupancy alone decides what is visible
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {pk_flags, pk_data};
   end

   // control state, cleared asynchronously so buffered words vanish at once
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q     <= 1'b0;
         rd_ptr_q     <= 1'b0;
         cnt_q        <= 2'd0;
         result_cnt_q <= 16'd0;
         ovf_cnt_q    <= 8'd0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         cnt_q        <= cnt_d;
         result_cnt_q <= result_cnt_d;
         ovf_cnt_q    <= ovf_cnt_d;
      end
   end
endmodule

// File: tb/tb_fp32_result_pack.sv
// tb_fp32_result_pack: directed vector table plus backpressure, counter-limit and reset sequences
module tb_fp32_result_pack;
   logic        clk = 1'b0, rst = 1'b1;
   logic        in_valid = 1'b0, in_ready, sign_in = 1'b0, zero_in = 1'b0;
   logic [9:0]  exp_in = '0;
   logic [22:0] sig_in = '0;
   logic        out_valid, out_ready = 1'b1;
   logic [31:0] out_data;
   logic [2:0]  out_flags;
   logic [15:0] result_cnt;
   logic [7:0]  ovf_cnt;
   int          checks = 0, errors = 0;

   typedef struct packed {
      logic        sign;
      logic [9:0]  exp;
      logic [22:0] sig;
      logic        zero;
      logic [31:0] data;
      logic [2:0]  flags;
   } vec_t;
   vec_t vecs [11];

   fp32_result_pack dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .sign_in(sign_in), .exp_in(exp_in), .sig_in(sig_in), .zero_in(zero_in),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_flags(out_flags), .result_cnt(result_cnt), .ovf_cnt(ovf_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, want);
      end
   endtask

   task automatic drive(input logic s, input logic [9:0] e, input logic [22:0] f, input logic z);
      sign_in = s; exp_in = e; sig_in = f; zero_in = z; in_valid = 1'b1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      #2;
      rst = 1'b0;
   endtask

   task automatic stream(input int n, input logic [9:0] e);
      drive(1'b0, e, 23'h1, 1'b0);
      repeat (n) @(posedge clk);
      #1;
      in_valid = 1'b0;
      tick();
   endtask

   initial begin
      logic [15:0] exp_rc;
      logic [7:0]  exp_oc;
      vecs[0]  = '{1'b1, 10'd127,  23'h400000, 1'b0, 32'hBFC00000, 3'b000};
      vecs[1]  = '{1'b0, 10'd256,  23'h000000, 1'b0, 32'h7F800000, 3'b100};
      vecs[2]  = '{1'b1, 10'h3FE,  23'h123456, 1'b0, 32'h80000000, 3'b010};
      vecs[3]  = '{1'b1, 10'd5,    23'h7FFFFF, 1'b1, 32'h00000000, 3'b001};
      vecs[4]  = '{1'b1, 10'd255,  23'h000001, 1'b0, 32'hFF800000, 3'b100};
      vecs[5]  = '{1'b0, 10'd0,    23'h000123, 1'b0, 32'h00000000, 3'b010};
      vecs[6]  = '{1'b0, 10'd254,  23'h7FFFFF, 1'b0, 32'h7F7FFFFF, 3'b000};
      vecs[7]  = '{1'b1, 10'd1,    23'h000000, 1'b0, 32'h80800000, 3'b000};
      vecs[8]  = '{1'b0, 10'h200,  23'h0000FF, 1'b0, 32'h00000000, 3'b010};
      vecs[9]  = '{1'b1, 10'h1FF,  23'h000000, 1'b0, 32'hFF800000, 3'b100};
      vecs[10] = '{1'b1, 10'd256,  23'h000000, 1'b1, 32'h00000000, 3'b001};

      #3;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_result_cnt", 32'(result_cnt), 32'd0);
      check("rst_ovf_cnt", 32'(ovf_cnt), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      exp_rc = '0;
      exp_oc = '0;
      for (int i = 0; i < 11; i++) begin
         drive(vecs[i].sign, vecs[i].exp, vecs[i].sig, vecs[i].zero);
         tick();
         in_valid = 1'b0;
         check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
         check($sformatf("vec%0d_data", i), out_data, vecs[i].data);
         check($sformatf("vec%0d_flags", i), 32'(out_flags), 32'(vecs[i].flags));
         tick();
         exp_rc = exp_rc + 16'd1;
         if (vecs[i].flags[2]) exp_oc = exp_oc + 8'd1;
         check($sformatf("vec%0d_result_cnt", i), 32'(result_cnt), 32'(exp_rc));
         check($sformatf("vec%0d_ovf_cnt", i), 32'(ovf_cnt), 32'(exp_oc));
         check($sformatf("vec%0d_drained", i), 32'(out_valid), 32'd0);
      end

      pulse_rst();
      out_ready = 1'b0;
      drive(1'b0, 10'd100, 23'h1, 1'b0);
      tick();
      check("bp_a_head", out_data, 32'h32000001);
      check("bp_ready_1", 32'(in_ready), 32'd1);
      drive(1'b0, 10'd101, 23'h2, 1'b0);
      tick();
      check("bp_full_ready", 32'(in_ready), 32'd0);
      check("bp_a_hold1", out_data, 32'h32000001);
      drive(1'b1, 10'd102, 23'h3, 1'b0);
      tick();
      check("bp_c_blocked", 32'(in_ready), 32'd0);
      check("bp_a_hold2", out_data, 32'h32000001);
      check("bp_a_flags", 32'(out_flags), 32'd0);
      out_ready = 1'b1;
      tick();
      check("bp_b_head", out_data, 32'h32800002);
      check("bp_rc1", 32'(result_cnt), 32'd1);
      tick();
      in_valid = 1'b0;
      check("bp_c_head", out_data, 32'hB3000003);
      check("bp_rc2", 32'(result_cnt), 32'd2);
      tick();
      check("bp_empty", 32'(out_valid), 32'd0);
      check("bp_rc3", 32'(result_cnt), 32'd3);

      pulse_rst();
      drive(1'b0, 10'd300, 23'h0, 1'b0);
      tick();
      in_valid = 1'b0;
      tick();
      out_ready = 1'b0;
      drive(1'b0, 10'd50, 23'h11, 1'b0);
      tick();
      drive(1'b0, 10'd51, 23'h22, 1'b0);
      tick();
      in_valid = 1'b0;
      check("mid_pre_cnt", 32'(result_cnt), 32'd1);
      check("mid_pre_full", 32'(in_ready), 32'd0);
      rst = 1'b1;
      #1;
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_ready", 32'(in_ready), 32'd1);
      check("mid_rst_rc", 32'(result_cnt), 32'd0);
      check("mid_rst_oc", 32'(ovf_cnt), 32'd0);
      #1;
      rst = 1'b0;
      out_ready = 1'b1;
      drive(1'b1, 10'd130, 23'h55, 1'b0);
      tick();
      in_valid = 1'b0;
      check("mid_d_valid", 32'(out_valid), 32'd1);
      check("mid_d_data", out_data, 32'hC1000055);
      tick();
      check("mid_d_only", 32'(out_valid), 32'd0);
      check("mid_d_rc", 32'(result_cnt), 32'd1);

      pulse_rst();
      stream(255, 10'd400);
      check("sat_oc_ff", 32'(ovf_cnt), 32'hFF);
      stream(1, 10'd400);
      check("sat_oc_hold", 32'(ovf_cnt), 32'hFF);
      check("sat_rc256", 32'(result_cnt), 32'd256);
      stream(65279, 10'd10);
      check("wrap_rc_ffff", 32'(result_cnt), 32'hFFFF);
      stream(1, 10'd10);
      check("wrap_rc_zero", 32'(result_cnt), 32'd0);
      check("wrap_oc_hold", 32'(ovf_cnt), 32'hFF);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/fp32_result_pack.md
FP32_RESULT_PACK -- requirements
Module: fp32_result_pack

Interface
REQ-001 SHALL have ports clk (input, 1, rising-edge clock) and rst (input, 1, reset); one clock domain; rst asynchronous, active-high.
REQ-002 SHALL have port in_valid (input, 1): a result word from the final adder is present.
REQ-003 SHALL have port in_ready (output, 1): the block accepts the word this cycle.
REQ-004 SHALL have port sign_in (input, 1): result sign from the adder controller.
REQ-005 SHALL have port exp_in (input, 10): signed two's-complement biased exponent, widened from the adder's 8-bit result.
REQ-006 SHALL have port sig_in (input, 23): rounded fraction without the hidden bit.
REQ-007 SHALL have port zero_in (input, 1): the adder sum was exactly zero.
REQ-008 SHALL have port out_valid (output, 1): out_data and out_flags are valid.
REQ-009 SHALL have port out_ready (input, 1): the consumer takes the word this cycle.
REQ-010 SHALL have port out_data (output, 32): IEEE-754 single word {sign, exp[7:0], frac[22:0]}.
REQ-011 SHALL have port out_flags (output, 3): {ovf, unf, zero}.
REQ-012 SHALL have port result_cnt (output, 16): number of words delivered.
REQ-013 SHALL have port ovf_cnt (output, 8): number of overflowed words delivered.

Function
REQ-014 SHALL accept an input word when in_valid && in_ready; SHALL deliver an output word when out_valid && out_ready.
REQ-015 SHALL classify each accepted word in the cycle it is accepted. Priority: zero_in, then exp_in >= 255 (signed), then exp_in <= 0 (signed), then normal.
REQ-016 zero_in=1 SHALL pack 32'h0000_0000 (+0, sign_in ignored) with flags 3'b001.
REQ-017 Overflow SHALL pack {sign_in, 8'hFF, 23'h0} (signed infinity) with flags 3'b100.
REQ-018 Underflow SHALL pack {sign_in, 31'h0} (flush to signed zero, no denormals) with flags 3'b010.
REQ-019 Normal SHALL pack {sign_in, exp_in[7:0], sig_in} with flags 3'b000.
REQ-020 SHALL store packed words in a 2-entry FIFO holding 32-bit data plus 3 flags, with 1-bit read and write pointers and a 2-bit occupancy count.
REQ-021 in_ready SHALL be decoded from registered state only: 1 when occupancy < 2, otherwise 0. There is no same-cycle pass-through when the FIFO is full, even if out_ready=1.
REQ-022 out_valid SHALL be 1 when occupancy > 0. out_data and out_flags SHALL show the head entry.
REQ-023 Latency: a word accepted at edge N SHALL be visible with out_valid=1 after edge N when the FIFO was empty.
REQ-024 Simultaneous push and pop at occupancy 1 SHALL leave occupancy at 1 and keep order.
REQ-025 Simultaneous push and pop at occupancy 0 is impossible, because nothing can be popped.
REQ-026 Words SHALL leave in acceptance order.
REQ-027 Pointers SHALL wrap 1 -> 0.
REQ-028 out_data and out_flags SHALL hold stable while out_valid=1 && out_ready=0.
REQ-029 result_cnt SHALL increment by 1 per delivered word and wrap from 16'hFFFF to 0.
REQ-030 ovf_cnt SHALL increment per delivered word whose ovf flag is set, and saturate at 8'hFF.
REQ-031 in_valid while in_ready=0 SHALL have no effect. Inputs are not required to stay stable while the FIFO is stalled.

Reset
REQ-032 rst=1 SHALL immediately clear both pointers and the occupancy count, without waiting for a clock edge.
REQ-033 rst=1 SHALL immediately clear result_cnt and ovf_cnt to 0.
REQ-034 During reset, out_valid SHALL be 0 and in_ready SHALL be 1; FIFO data contents are don't-care.
REQ-035 Reset asserted mid-operation SHALL discard buffered words; no word accepted before reset SHALL appear after reset.
REQ-036 First acceptance SHALL be possible on the first rising edge after rst deasserts.

Verification
REQ-037 Normal pack: sign_in=1, exp_in=10'd127, sig_in=23'h400000, out_ready=1 -> next cycle out_data=32'hBFC00000, flags=000, result_cnt=1.
REQ-038 Overflow: exp_in=10'd256, sign_in=0 -> out_data=32'h7F800000, flags=100, ovf_cnt=1.
REQ-039 Underflow and zero: exp_in=10'h3FE (-2), sign_in=1 -> out_data=32'h80000000, flags=010; then zero_in=1, sign_in=1 -> out_data=32'h00000000, flags=001.
REQ-040 Backpressure: out_ready=0 and 3 consecutive valid words A, B, C -> A and B accepted, in_ready=0 on C's cycle, C held. Raise out_ready -> A, B, C delivered in order; result_cnt=3.
REQ-041 Counter limits: preload ovf_cnt=8'hFF and deliver 1 overflow word -> ovf_cnt stays 8'hFF. Preload result_cnt=16'hFFFF and deliver 1 word -> result_cnt=0.
REQ-042 Reset mid-stream: FIFO holds 2 words and rst pulses between edges -> out_valid=0 and counters=0 immediately; after release, a new word D is the first word delivered.
